// File: rtl/decode_queue.sv
// decode_queue: circular FIFO of fetched instructions and their PCs between
// fetch and execute. The head entry is decoded combinationally into register
// fields, a sign-extended immediate and an illegal-opcode flag. When the
// queue is empty the decoder sees RESET_INSN and out_pc reads as zero.
module decode_queue #(
  parameter int          XLEN       = 32,
  parameter int          DEPTH      = 2,
  parameter logic [31:0] RESET_INSN = 32'h0000_0013
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [31:0]                in_instr,
  input  logic [XLEN-1:0]            in_pc,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [XLEN-1:0]            out_pc,
  output logic [6:0]                 opcode,
  output logic [4:0]                 rd,
  output logic [4:0]                 rs1,
  output logic [4:0]                 rs2,
  output logic [2:0]                 funct3,
  output logic [6:0]                 funct7,
  output logic [XLEN-1:0]            imm,
  output logic                       illegal,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  // RV32I base opcodes
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  // Storage (intentionally not reset; validity is tracked by count)
  logic [31:0]     mem_instr [DEPTH];
  logic [XLEN-1:0] mem_pc    [DEPTH];

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             full;
  logic             empty;
  logic             push;
  logic             pop;
  logic [31:0]      head_instr;

  // Sign-extended immediate for the instruction format implied by the opcode.
  // Each format is first assembled as a signed 32-bit value so that the size
  // cast to XLEN extends from instr[31].
  function automatic logic [XLEN-1:0] decode_imm(input logic [31:0] i);
    logic signed [31:0] v;
    v = '0;
    case (i[6:0])
      OP_LOAD, OP_IMM, OP_JALR, OP_SYSTEM:
        v = 32'(signed'(i[31:20]));
      OP_STORE:
        v = 32'(signed'({i[31:25], i[11:7]}));
      OP_BRANCH:
        v = 32'(signed'({i[31], i[7], i[30:25], i[11:8], 1'b0}));
      OP_LUI, OP_AUIPC:
        v = signed'({i[31:12], 12'b0});
      OP_JAL:
        v = 32'(signed'({i[31], i[19:12], i[20], i[30:21], 1'b0}));
      default:
        v = '0;
    endcase
    return XLEN'(v);
  endfunction

  // True for every RV32I base opcode; all of them end in 2'b11, so a
  // compressed-encoding prefix is rejected by the same check.
  function automatic logic legal_opcode(input logic [6:0] op);
    logic ok;
    case (op)
      OP_LOAD, OP_FENCE, OP_IMM, OP_AUIPC, OP_STORE, OP_REG,
      OP_LUI, OP_BRANCH, OP_JALR, OP_JAL, OP_SYSTEM: ok = 1'b1;
      default:                                       ok = 1'b0;
    endcase
    return ok;
  endfunction

  assign full      = (count == CNT_W'(DEPTH));
  assign empty     = (count == '0);
  assign in_ready  = !full;
  assign out_valid = !empty;
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  // Write the offered instruction into the tail slot; a flush discards it
  always_ff @(posedge clk) begin
    if (push && !flush) begin
      mem_instr[wr_ptr] <= in_instr;
      mem_pc[wr_ptr]    <= in_pc;
    end
  end

  // Pointer and occupancy bookkeeping; flush overrides any push or pop
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Combinational decode of the head entry (RESET_INSN when empty)
  always_comb begin
    head_instr = RESET_INSN;
    out_pc     = '0;
    if (!empty) begin
      head_instr = mem_instr[rd_ptr];
      out_pc     = mem_pc[rd_ptr];
    end
    opcode  = head_instr[6:0];
    rd      = head_instr[11:7];
    funct3  = head_instr[14:12];
    rs1     = head_instr[19:15];
    rs2     = head_instr[24:20];
    funct7  = head_instr[31:25];
    imm     = decode_imm(head_instr);
    illegal = !empty && !legal_opcode(head_instr[6:0]);
  end

endmodule

// File: tb/tb_decode_queue.sv
// Directed bench for decode_queue (XLEN=32, DEPTH=2).
module tb_decode_queue;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [31:0] in_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [6:0]  opcode;
  logic [4:0]  rd;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] imm;
  logic        illegal;
  logic [1:0]  count;

  int n_cmp = 0;
  int n_bad = 0;

  decode_queue #(.XLEN(32), .DEPTH(2), .RESET_INSN(32'h0000_0013)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .opcode(opcode), .rd(rd), .rs1(rs1), .rs2(rs2), .funct3(funct3), .funct7(funct7),
    .imm(imm), .illegal(illegal), .count(count)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_instr = 32'h0; in_pc = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL rst_out_valid got=%0h exp=0", out_valid); end
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL rst_in_ready got=%0h exp=1", in_ready); end
    n_cmp++; if (count !== 2'd0) begin n_bad++; $display("FAIL rst_count got=%0d exp=0", count); end
    n_cmp++; if (opcode !== 7'h13) begin n_bad++; $display("FAIL rst_opcode got=%0h exp=13", opcode); end
    n_cmp++; if (imm !== 32'h0) begin n_bad++; $display("FAIL rst_imm got=%0h exp=0", imm); end
    n_cmp++; if (illegal !== 1'b0) begin n_bad++; $display("FAIL rst_illegal got=%0h exp=0", illegal); end
    n_cmp++; if (out_pc !== 32'h0) begin n_bad++; $display("FAIL rst_out_pc got=%0h exp=0", out_pc); end
    n_cmp++; if ({rd, rs1, rs2, funct3, funct7} !== 25'h0) begin n_bad++; $display("FAIL rst_fields got=%0h exp=0", {rd, rs1, rs2, funct3, funct7}); end
    rst = 1'b1;
    tick();
  endtask

  task automatic test_single_push;
    in_valid = 1'b1; in_instr = 32'hFFF0_0093; in_pc = 32'h100;
    tick();
    in_valid = 1'b0;
    n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL push_out_valid got=%0h exp=1", out_valid); end
    n_cmp++; if (rd !== 5'd1) begin n_bad++; $display("FAIL push_rd got=%0d exp=1", rd); end
    n_cmp++; if (imm !== 32'hFFFF_FFFF) begin n_bad++; $display("FAIL push_imm got=%0h exp=ffffffff", imm); end
    n_cmp++; if (out_pc !== 32'h100) begin n_bad++; $display("FAIL push_out_pc got=%0h exp=100", out_pc); end
    n_cmp++; if (count !== 2'd1) begin n_bad++; $display("FAIL push_count got=%0d exp=1", count); end
    n_cmp++; if (funct7 !== 7'h7F || rs1 !== 5'd0 || funct3 !== 3'd0) begin n_bad++; $display("FAIL push_fields got=%0h/%0h/%0h exp=7f/0/0", funct7, rs1, funct3); end
  endtask

  task automatic test_fill_and_wrap;
    // second entry fills the queue
    in_valid = 1'b1; in_instr = 32'h0020_0113; in_pc = 32'h104;
    tick();
    n_cmp++; if (count !== 2'd2) begin n_bad++; $display("FAIL fill_count got=%0d exp=2", count); end
    n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL fill_in_ready got=%0h exp=0", in_ready); end
    // third offer is held off for two cycles
    in_instr = 32'h0030_0193; in_pc = 32'h108;
    tick(); tick();
    n_cmp++; if (count !== 2'd2) begin n_bad++; $display("FAIL held_count got=%0d exp=2", count); end
    n_cmp++; if (out_pc !== 32'h100 || rd !== 5'd1) begin n_bad++; $display("FAIL held_head got=%0h/%0d exp=100/1", out_pc, rd); end
    // pop while full: in_ready was low at the edge, so only the pop happens
    out_ready = 1'b1;
    tick();
    n_cmp++; if (count !== 2'd1) begin n_bad++; $display("FAIL fullpop_count got=%0d exp=1", count); end
    n_cmp++; if (out_pc !== 32'h104 || rd !== 5'd2) begin n_bad++; $display("FAIL fullpop_head got=%0h/%0d exp=104/2", out_pc, rd); end
    // push and pop together: count unchanged, rd_ptr wraps 1 -> 0
    tick();
    n_cmp++; if (count !== 2'd1) begin n_bad++; $display("FAIL pushpop_count got=%0d exp=1", count); end
    n_cmp++; if (out_pc !== 32'h108 || rd !== 5'd3) begin n_bad++; $display("FAIL pushpop_head got=%0h/%0d exp=108/3", out_pc, rd); end
    // refill behind the head, then pop to check ordering after the wrap
    out_ready = 1'b0; in_instr = 32'h0040_0213; in_pc = 32'h10C;
    tick();
    in_valid = 1'b0;
    n_cmp++; if (count !== 2'd2) begin n_bad++; $display("FAIL refill_count got=%0d exp=2", count); end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    n_cmp++; if (out_pc !== 32'h10C || rd !== 5'd4 || count !== 2'd1) begin n_bad++; $display("FAIL order_head got=%0h/%0d/%0d exp=10c/4/1", out_pc, rd, count); end
  endtask

  task automatic test_flush;
    in_valid = 1'b1; in_instr = 32'h0050_0293; in_pc = 32'h110;
    tick();
    n_cmp++; if (count !== 2'd2) begin n_bad++; $display("FAIL preflush_count got=%0d exp=2", count); end
    flush = 1'b1; out_ready = 1'b1; in_instr = 32'h0060_0313; in_pc = 32'h114;
    #1;
    n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL flush_in_ready got=%0h exp=0", in_ready); end
    tick();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    n_cmp++; if (count !== 2'd0 || out_valid !== 1'b0) begin n_bad++; $display("FAIL flush_empty got=%0d/%0h exp=0/0", count, out_valid); end
    n_cmp++; if (opcode !== 7'h13 || out_pc !== 32'h0) begin n_bad++; $display("FAIL flush_outputs got=%0h/%0h exp=13/0", opcode, out_pc); end
    // offered instruction was dropped: nothing appears without a new push
    tick();
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL flush_dropped got=%0h exp=0", out_valid); end
    // pointers restart at 0: a new push shows up at the head
    in_valid = 1'b1; in_instr = 32'h0070_0393; in_pc = 32'h200;
    tick();
    in_valid = 1'b0;
    n_cmp++; if (out_pc !== 32'h200 || rd !== 5'd7 || count !== 2'd1) begin n_bad++; $display("FAIL postflush_head got=%0h/%0d/%0d exp=200/7/1", out_pc, rd, count); end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_immediates;
    logic [31:0] vin  [8];
    logic [31:0] vimm [8];
    logic        vill [8];
    vin[0] = 32'hFE11_2E23; vimm[0] = 32'hFFFF_FFFC; vill[0] = 1'b0; // sw
    vin[1] = 32'hFE00_0EE3; vimm[1] = 32'hFFFF_FFFC; vill[1] = 1'b0; // beq
    vin[2] = 32'h0080_006F; vimm[2] = 32'h0000_0008; vill[2] = 1'b0; // jal
    vin[3] = 32'h1234_50B7; vimm[3] = 32'h1234_5000; vill[3] = 1'b0; // lui
    vin[4] = 32'h0000_007F; vimm[4] = 32'h0000_0000; vill[4] = 1'b1; // unknown
    vin[5] = 32'h0020_81B3; vimm[5] = 32'h0000_0000; vill[5] = 1'b0; // add (R)
    vin[6] = 32'h0000_000F; vimm[6] = 32'h0000_0000; vill[6] = 1'b0; // fence
    vin[7] = 32'h8000_0003; vimm[7] = 32'hFFFF_F800; vill[7] = 1'b0; // lb, imm -2048
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1; in_instr = vin[i]; in_pc = 32'h300 + 32'(i * 4);
      tick();
      in_valid = 1'b0;
      n_cmp++; if (imm !== vimm[i]) begin n_bad++; $display("FAIL imm_%0d got=%0h exp=%0h", i, imm, vimm[i]); end
      n_cmp++; if (illegal !== vill[i]) begin n_bad++; $display("FAIL illegal_%0d got=%0h exp=%0h", i, illegal, vill[i]); end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
    end
    n_cmp++; if (illegal !== 1'b0 || count !== 2'd0) begin n_bad++; $display("FAIL empty_illegal got=%0h/%0d exp=0/0", illegal, count); end
  endtask

  task automatic test_async_reset;
    in_valid = 1'b1; in_instr = 32'h0000_007F; in_pc = 32'h400;
    tick();
    in_valid = 1'b0;
    n_cmp++; if (out_valid !== 1'b1 || illegal !== 1'b1) begin n_bad++; $display("FAIL prearst got=%0h/%0h exp=1/1", out_valid, illegal); end
    #2 rst = 1'b0;
    #1;
    n_cmp++; if (out_valid !== 1'b0 || count !== 2'd0 || in_ready !== 1'b1) begin n_bad++; $display("FAIL arst_ctrl got=%0h/%0d/%0h exp=0/0/1", out_valid, count, in_ready); end
    n_cmp++; if (opcode !== 7'h13 || out_pc !== 32'h0 || illegal !== 1'b0) begin n_bad++; $display("FAIL arst_decode got=%0h/%0h/%0h exp=13/0/0", opcode, out_pc, illegal); end
    tick();
    rst = 1'b1;
    tick();
  endtask

  initial begin
    test_reset();
    test_single_push();
    test_fill_and_wrap();
    test_flush();
    test_immediates();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
